// File: rtl/matrix_row_scanner_pkg.sv
// Shared types and helpers for the LED matrix row scanner.
package matrix_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } scan_state_t;

   // Level of every row/column pin when the matrix is dark.
   localparam logic ALL_OFF = 1'b1;

   // Active-low one-hot row drive; row idx lights bit rows-1-idx (rows <= 64).
   function automatic logic [63:0] row_onehot_n(input int idx, input int rows);
      logic [63:0] hot;
      hot = 64'd1 << (rows - 1 - idx);
      return ~hot;
   endfunction

endpackage

// File: rtl/matrix_row_scanner_if.sv
// Pixel-data and pin-drive bundle between the frame buffer side and the row scanner.
interface matrix_row_scanner_if #(
   parameter int ROWS = 8,
   parameter int COLS = 8
);
   localparam int ROW_W = $clog2(ROWS);

   logic             en;
   logic             dir;
   logic [COLS-1:0]  col_data;
   logic [ROWS-1:0]  row_n;
   logic [COLS-1:0]  col_n;
   logic [ROW_W-1:0] row_idx;
   logic             frame_start;

   modport master (
      output en, dir, col_data,
      input  row_n, col_n, row_idx, frame_start
   );

   modport slave (
      input  en, dir, col_data,
      output row_n, col_n, row_idx, frame_start
   );
endinterface

// File: rtl/matrix_row_scanner_prescaler.sv
// Modulo-DIV cycle counter; tick marks the last cycle of each DIV-cycle period.
module scan_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;

   assign tick = en & ~clr & (cnt_r == LAST);

   // Count while enabled, wrapping at DIV-1; clr holds the count at zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         cnt_r <= (cnt_r == LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end
endmodule

// File: rtl/matrix_row_scanner.sv
// LED dot-matrix row scanner. Define ROW_BLANK_EN to insert BLANK_CYC dark cycles between rows.
module matrix_row_scanner
   import matrix_scan_pkg::*;
#(
   parameter int ROWS      = 8,
   parameter int COLS      = 8,
   parameter int CLK_DIV   = 3125,
   parameter int BLANK_CYC = 4
) (
   input logic               clk,
   input logic               rst,
   matrix_row_scanner_if.slave bus
);
   localparam int               ROW_W    = $clog2(ROWS);
   localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(ROWS - 1);

   if (ROWS < 2 || ROWS > 64 || CLK_DIV < 2 || BLANK_CYC < 1) begin : g_bad_param
      $error("matrix_row_scanner: parameter out of range");
   end

   scan_state_t      state_r;
   logic [ROWS-1:0]  row_n_r;
   logic [COLS-1:0]  col_n_r;
   logic [ROW_W-1:0] idx_r;
   logic             frame_start_r;
   logic             frame_pend_r;
   logic             dir_q_r;

   logic             show_tick_s;
   logic             row_last_s;
   logic [ROW_W-1:0] next_idx_s;
   logic             next_dir_s;

   scan_prescaler #(.DIV(CLK_DIV)) u_show_div (
      .clk  (clk),
      .rst  (rst),
      .clr  ((state_r != ST_SHOW) || !bus.en),
      .en   (state_r == ST_SHOW),
      .tick (show_tick_s)
   );

`ifdef ROW_BLANK_EN
   logic blank_tick_s;

   scan_prescaler #(.DIV(BLANK_CYC)) u_blank_div (
      .clk  (clk),
      .rst  (rst),
      .clr  ((state_r != ST_BLANK) || !bus.en),
      .en   (state_r == ST_BLANK),
      .tick (blank_tick_s)
   );
`endif

   // Next row index; direction is re-sampled only when a frame wraps.
   always_comb begin
      row_last_s = dir_q_r ? (idx_r == {ROW_W{1'b0}}) : (idx_r == LAST_IDX);
      if (row_last_s) begin
         next_dir_s = bus.dir;
         next_idx_s = bus.dir ? LAST_IDX : {ROW_W{1'b0}};
      end else begin
         next_dir_s = dir_q_r;
         next_idx_s = dir_q_r ? (idx_r - ROW_W'(1)) : (idx_r + ROW_W'(1));
      end
   end

   // Scan FSM with registered pin drive, row index and frame marker.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         row_n_r       <= {ROWS{ALL_OFF}};
         col_n_r       <= {COLS{ALL_OFF}};
         idx_r         <= {ROW_W{1'b0}};
         frame_start_r <= 1'b0;
         frame_pend_r  <= 1'b1;
         dir_q_r       <= 1'b0;
      end else if (!bus.en) begin
         state_r       <= ST_IDLE;
         row_n_r       <= {ROWS{ALL_OFF}};
         col_n_r       <= {COLS{ALL_OFF}};
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               state_r       <= ST_SHOW;
               row_n_r       <= ROWS'(row_onehot_n(32'(idx_r), ROWS));
               col_n_r       <= ~bus.col_data;
               frame_start_r <= frame_pend_r;
               frame_pend_r  <= 1'b0;
            end
            ST_SHOW: begin
               if (show_tick_s) begin
                  idx_r   <= next_idx_s;
                  dir_q_r <= next_dir_s;
`ifdef ROW_BLANK_EN
                  state_r      <= ST_BLANK;
                  row_n_r      <= {ROWS{ALL_OFF}};
                  col_n_r      <= {COLS{ALL_OFF}};
                  frame_pend_r <= row_last_s;
`else
                  row_n_r       <= ROWS'(row_onehot_n(32'(next_idx_s), ROWS));
                  col_n_r       <= ~bus.col_data;
                  frame_start_r <= row_last_s;
`endif
               end else begin
                  state_r <= ST_SHOW;
               end
            end
`ifdef ROW_BLANK_EN
            ST_BLANK: begin
               if (blank_tick_s) begin
                  state_r       <= ST_SHOW;
                  row_n_r       <= ROWS'(row_onehot_n(32'(idx_r), ROWS));
                  col_n_r       <= ~bus.col_data;
                  frame_start_r <= frame_pend_r;
                  frame_pend_r  <= 1'b0;
               end else begin
                  state_r <= ST_BLANK;
               end
            end
`endif
            default: begin
               state_r <= ST_IDLE;
               row_n_r <= {ROWS{ALL_OFF}};
               col_n_r <= {COLS{ALL_OFF}};
            end
         endcase
      end
   end

   assign bus.row_n       = row_n_r;
   assign bus.col_n       = col_n_r;
   assign bus.row_idx     = idx_r;
   assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_matrix_row_scanner.sv
// Directed, table-driven check of the matrix row scanner (either ROW_BLANK_EN build).
module tb_matrix_row_scanner;
   localparam int ROWS      = 8;
   localparam int COLS      = 8;
   localparam int CLK_DIV   = 4;
   localparam int BLANK_CYC = 2;
`ifdef ROW_BLANK_EN
   localparam int GAP = BLANK_CYC;
`else
   localparam int GAP = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matrix_row_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   matrix_row_scanner #(
      .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       en;
      logic       dir;
      logic [7:0] col;
      logic [7:0] row_n;
      logic [7:0] col_n;
      logic [2:0] idx;
      logic       fs;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [7:0] pat(input int k);
      return 8'h81 ^ (8'(k) * 8'h13);
   endfunction

   function automatic logic [7:0] rown(input int k);
      logic [7:0] b;
      b = 8'h80 >> k;
      return ~b;
   endfunction

   // One row: CLK_DIV lit cycles, then GAP dark cycles already showing the next index.
   function automatic void push_row(input int k, input int nxt, input logic d, input logic fs);
      vec_t v;
      for (int c = 0; c < CLK_DIV; c++) begin
         v.en = 1'b1; v.dir = d; v.col = pat(k);
         v.row_n = rown(k); v.col_n = ~pat(k); v.idx = 3'(k);
         v.fs = (c == 0) ? fs : 1'b0;
         vecs.push_back(v);
      end
      for (int g = 0; g < GAP; g++) begin
         v.en = 1'b1; v.dir = d; v.col = pat(nxt);
         v.row_n = 8'hFF; v.col_n = 8'hFF; v.idx = 3'(nxt); v.fs = 1'b0;
         vecs.push_back(v);
      end
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] r, input logic [7:0] c,
                          input logic [2:0] i, input logic f);
      chk({tag, ".row_n"}, bus.row_n, r);
      chk({tag, ".col_n"}, bus.col_n, c);
      chk({tag, ".row_idx"}, 8'(bus.row_idx), 8'(i));
      chk({tag, ".frame_start"}, 8'(bus.frame_start), 8'(f));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // At most one row line may ever be driven low.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ($countones(~bus.row_n) > 1) begin
            errors++;
            $display("FAIL onehot: row_n=%0h has more than one low bit", bus.row_n);
         end
      end
   end

   initial begin
      bus.en = 1'b0; bus.dir = 1'b0; bus.col_data = 8'h00;
      rst = 1'b1;
      step(); step();
      chk_all("reset", 8'hFF, 8'hFF, 3'd0, 1'b0);
      rst = 1'b0;
      step();
      chk_all("idle", 8'hFF, 8'hFF, 3'd0, 1'b0);

      push_row(0, 1, 1'b0, 1'b1);
      for (int k = 1; k < 8; k++) push_row(k, (k + 1) % 8, 1'b0, 1'b0);
      push_row(0, 1, 1'b0, 1'b1);
      push_row(1, 2, 1'b0, 1'b0);
      push_row(2, 3, 1'b0, 1'b0);
      push_row(3, 4, 1'b1, 1'b0);
      push_row(4, 5, 1'b1, 1'b0);
      push_row(5, 6, 1'b1, 1'b0);
      push_row(6, 7, 1'b1, 1'b0);
      push_row(7, 7, 1'b1, 1'b0);
      push_row(7, 6, 1'b1, 1'b1);
      push_row(6, 5, 1'b1, 1'b0);

      foreach (vecs[i]) begin
         bus.en = vecs[i].en; bus.dir = vecs[i].dir; bus.col_data = vecs[i].col;
         step();
         chk_all($sformatf("v%0d", i), vecs[i].row_n, vecs[i].col_n, vecs[i].idx, vecs[i].fs);
      end

      // Drop enable in the 2nd cycle of row 5, then resume with a full dwell.
      bus.col_data = pat(5);
      step(); chk_all("r5c1", rown(5), ~pat(5), 3'd5, 1'b0);
      step(); chk_all("r5c2", rown(5), ~pat(5), 3'd5, 1'b0);
      bus.en = 1'b0;
      step(); chk_all("en_off", 8'hFF, 8'hFF, 3'd5, 1'b0);
      step(); chk_all("en_off_hold", 8'hFF, 8'hFF, 3'd5, 1'b0);
      bus.en = 1'b1;
      for (int c = 0; c < CLK_DIV; c++) begin
         step(); chk_all($sformatf("resume%0d", c), rown(5), ~pat(5), 3'd5, 1'b0);
      end
      bus.col_data = pat(4);
      for (int g = 0; g < GAP; g++) begin
         step(); chk_all($sformatf("gap4_%0d", g), 8'hFF, 8'hFF, 3'd4, 1'b0);
      end
      step(); chk_all("r4c1", rown(4), ~pat(4), 3'd4, 1'b0);
      bus.col_data = pat(3);
      step(); step(); step();
      step();
      chk_all("r4end", (GAP > 0) ? 8'hFF : rown(3), (GAP > 0) ? 8'hFF : ~pat(3), 3'd3, 1'b0);

      // Reset at the row boundary (mid-BLANK when blanking is built in).
      rst = 1'b1;
      step(); chk_all("rst_mid", 8'hFF, 8'hFF, 3'd0, 1'b0);
      rst = 1'b0; bus.col_data = 8'h81;
      step(); chk_all("post_rst", 8'h7F, 8'h7E, 3'd0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
